// File: rtl/calc_fsm_undo_stack.sv
// calc_fsm_undo_stack
// Calculator core: four-stage operand/op entry FSM, a registered ALU and a
// DEPTH-deep circular history of completed calculations that undo can pop.
//
// State | Meaning
// S_A   | waiting for operand A (display follows sw)
// S_B   | waiting for operand B (display follows sw)
// S_OP  | waiting for op select (display previews sw[1:0])
// S_RES | result registered and displayed
//
// Optional feature macro: HIST_OVERWRITE_EN
//   defined     : a push into a full history overwrites the oldest entry
//   not defined : a push into a full history is discarded and drop pulses
module calc_fsm_undo_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_enter,
  input  logic                       btn_undo,
  input  logic [W-1:0]               sw,
  output logic [W:0]                 display_val,
  output logic [1:0]                 state,
  output logic                       neg,
  output logic [$clog2(DEPTH+1)-1:0] hist_count,
  output logic                       hist_full,
  output logic                       drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_t;

  state_t         cur_state;
  state_t         nxt_state;

  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [1:0]     op_reg;
  logic [W:0]     result_reg;

  logic [W-1:0]   hist_a      [DEPTH];
  logic [W-1:0]   hist_b      [DEPTH];
  logic [1:0]     hist_op     [DEPTH];
  logic [W:0]     hist_result [DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  wr_next;
  logic [PW-1:0]  rd_idx;
  logic [CW-1:0]  count;
  logic           full;

  logic           enter_ev;
  logic           undo_ev;
  logic           ld_a;
  logic           ld_b;
  logic           ld_op;
  logic           do_push;
  logic           do_pop;
  logic           push_wr;

  // Pressing both buttons in the same cycle is treated as no press at all.
  assign enter_ev = btn_enter & ~btn_undo;
  assign undo_ev  = btn_undo & ~btn_enter;

  assign full    = (count == CW'(DEPTH));
  assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_idx  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);

`ifdef HIST_OVERWRITE_EN
  // When full, wr_ptr already points at the oldest entry, so writing there
  // replaces it and the ring keeps its DEPTH most recent calculations.
  assign push_wr = do_push;
`else
  assign push_wr = do_push & ~full;
`endif

  function automatic logic [W:0] alu_f(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic [1:0]   f);
    logic [W:0] r;
    r = '0;
    case (f)
      2'b00:   r = {1'b0, x} + {1'b0, y};
      2'b01:   r = {1'b0, x} - {1'b0, y};
      2'b10:   r = {1'b0, x & y};
      default: r = {1'b0, x | y};
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_A;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state decode and one-cycle datapath strobes.
  always_comb begin
    nxt_state = cur_state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (cur_state)
      S_A: begin
        if (enter_ev) begin
          ld_a      = 1'b1;
          nxt_state = S_B;
        end else if (undo_ev && (count != '0)) begin
          do_pop    = 1'b1;
          nxt_state = S_RES;
        end
      end
      S_B: begin
        if (enter_ev) begin
          ld_b      = 1'b1;
          nxt_state = S_OP;
        end else if (undo_ev) begin
          nxt_state = S_A;
        end
      end
      S_OP: begin
        if (enter_ev) begin
          ld_op     = 1'b1;
          nxt_state = S_RES;
        end else if (undo_ev) begin
          nxt_state = S_B;
        end
      end
      S_RES: begin
        if (enter_ev) begin
          do_push   = 1'b1;
          nxt_state = S_A;
        end else if (undo_ev) begin
          nxt_state = S_OP;
        end
      end
      default: nxt_state = S_A;
    endcase
  end

  // Operand, op and result registers; a pop restores a whole calculation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else begin
      if (ld_a) begin
        a_reg <= sw;
      end
      if (ld_b) begin
        b_reg <= sw;
      end
      if (ld_op) begin
        op_reg     <= sw[1:0];
        result_reg <= alu_f(a_reg, b_reg, sw[1:0]);
      end
      if (do_push) begin
        a_reg      <= '0;
        b_reg      <= '0;
        op_reg     <= '0;
        result_reg <= '0;
      end
      if (do_pop) begin
        a_reg      <= hist_a[rd_idx];
        b_reg      <= hist_b[rd_idx];
        op_reg     <= hist_op[rd_idx];
        result_reg <= hist_result[rd_idx];
      end
    end
  end

  // History storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      hist_a[wr_ptr]      <= a_reg;
      hist_b[wr_ptr]      <= b_reg;
      hist_op[wr_ptr]     <= op_reg;
      hist_result[wr_ptr] <= result_reg;
    end
  end

  // History write pointer, occupancy and the lost-push pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (push_wr) begin
        wr_ptr <= wr_next;
        if (!full) begin
          count <= count + CW'(1);
        end
      end else if (do_pop) begin
        wr_ptr <= rd_idx;
        count  <= count - CW'(1);
      end
`ifdef HIST_OVERWRITE_EN
      drop <= 1'b0;
`else
      drop <= do_push & full;
`endif
    end
  end

  // Display mux and status flags.
  always_comb begin
    display_val = {1'b0, sw};
    case (cur_state)
      S_OP:    display_val = {{(W - 1){1'b0}}, sw[1:0]};
      S_RES:   display_val = result_reg;
      default: display_val = {1'b0, sw};
    endcase
  end

  assign state      = cur_state;
  assign neg        = (cur_state == S_RES) & result_reg[W];
  assign hist_count = count;
  assign hist_full  = full;

endmodule

// File: tb/tb_calc_fsm_undo_stack.sv
// Self-checking bench for calc_fsm_undo_stack (W=16, DEPTH=4).
// Expected values are queued as stimulus is applied and popped at each check.
module tb_calc_fsm_undo_stack;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_enter = 1'b0;
  logic         btn_undo = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W:0]   display_val;
  logic [1:0]   state;
  logic         neg;
  logic [2:0]   hist_count;
  logic         hist_full;
  logic         drop;

  int          n_assert = 0;
  int          n_fail = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_hist[$];

  calc_fsm_undo_stack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_enter   (btn_enter),
    .btn_undo    (btn_undo),
    .sw          (sw),
    .display_val (display_val),
    .state       (state),
    .neg         (neg),
    .hist_count  (hist_count),
    .hist_full   (hist_full),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_m(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0:    r = (a + b) & 32'h1FFFF;
      2'd1:    r = (a - b) & 32'h1FFFF;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic press(input logic e, input logic u, input logic [W-1:0] v);
    @(negedge clk);
    sw        = v;
    btn_enter = e;
    btn_undo  = u;
    @(negedge clk);
    btn_enter = 1'b0;
    btn_undo  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_hist.delete();
  endtask

  initial begin
    logic [31:0] r;
    logic        exp_drop;

    // reset state
    reset = 1'b0;
    sw    = 16'h1234;
    #3;
    expect_val("rst_state", 32'd0);     check(32'(state));
    expect_val("rst_hist", 32'd0);      check(32'(hist_count));
    expect_val("rst_disp", 32'h01234);  check(32'(display_val));
    expect_val("rst_neg", 32'd0);       check(32'(neg));
    expect_val("rst_full", 32'd0);      check(32'(hist_full));
    expect_val("rst_drop", 32'd0);      check(32'(drop));
    @(negedge clk);
    reset = 1'b1;

    // async reset in the middle of S_OP
    press(1'b1, 1'b0, 16'h0011);
    press(1'b1, 1'b0, 16'h0022);
    expect_val("t1_in_op", 32'd2);      check(32'(state));
    #2;
    sw    = 16'h00AB;
    reset = 1'b0;
    #1;
    expect_val("t1_state", 32'd0);      check(32'(state));
    expect_val("t1_disp", 32'h000AB);   check(32'(display_val));
    expect_val("t1_neg", 32'd0);        check(32'(neg));
    expect_val("t1_hist", 32'd0);       check(32'(hist_count));
    @(negedge clk);
    reset = 1'b1;

    // add with carry out, then push
    press(1'b1, 1'b0, 16'hFFFF);
    press(1'b1, 1'b0, 16'h0001);
    press(1'b1, 1'b0, 16'h0000);
    r = alu_m(32'hFFFF, 32'h1, 2'd0);
    expect_val("t2_disp", r);           check(32'(display_val));
    expect_val("t2_neg", 32'd1);        check(32'(neg));
    expect_val("t2_state", 32'd3);      check(32'(state));
    press(1'b1, 1'b0, 16'h0000);
    model_hist.push_back(r);
    expect_val("t2_pstate", 32'd0);     check(32'(state));
    expect_val("t2_hist", 32'd1);       check(32'(hist_count));

    // subtract with borrow, undo to S_OP, redo as add
    press(1'b1, 1'b0, 16'd3);
    press(1'b1, 1'b0, 16'd5);
    press(1'b1, 1'b0, 16'd1);
    expect_val("t3_sub", alu_m(32'd3, 32'd5, 2'd1)); check(32'(display_val));
    expect_val("t3_neg", 32'd1);        check(32'(neg));
    press(1'b0, 1'b1, 16'd1);
    expect_val("t3_undo", 32'd2);       check(32'(state));
    expect_val("t3_prev", 32'd1);       check(32'(display_val));
    press(1'b1, 1'b0, 16'd0);
    expect_val("t3_add", alu_m(32'd3, 32'd5, 2'd0)); check(32'(display_val));
    expect_val("t3_neg2", 32'd0);       check(32'(neg));
    press(1'b1, 1'b0, 16'd0);
    expect_val("t3_hist", 32'd2);       check(32'(hist_count));

    pulse_reset();
    expect_val("rst2_hist", 32'd0);     check(32'(hist_count));

    // simultaneous buttons ignored; undo in S_A with empty history ignored
    press(1'b1, 1'b0, 16'd7);
    expect_val("t5_b", 32'd1);          check(32'(state));
    press(1'b1, 1'b1, 16'd9);
    expect_val("t5_both", 32'd1);       check(32'(state));
    expect_val("t5_disp", 32'd9);       check(32'(display_val));
    press(1'b0, 1'b1, 16'd0);
    expect_val("t5_to_a", 32'd0);       check(32'(state));
    press(1'b0, 1'b1, 16'd0);
    expect_val("t5_empty", 32'd0);      check(32'(state));
    expect_val("t5_hist", 32'd0);       check(32'(hist_count));

    // and / or, undo back to S_B keeps A
    press(1'b1, 1'b0, 16'h00F0);
    press(1'b0, 1'b1, 16'h0000);
    expect_val("t6_back", 32'd0);       check(32'(state));
    press(1'b1, 1'b0, 16'h00F0);
    press(1'b1, 1'b0, 16'h0F0F);
    press(1'b1, 1'b0, 16'd2);
    expect_val("t6_and", alu_m(32'hF0, 32'hF0F, 2'd2)); check(32'(display_val));
    press(1'b0, 1'b1, 16'd2);
    press(1'b1, 1'b0, 16'd3);
    expect_val("t6_or", alu_m(32'hF0, 32'hF0F, 2'd3)); check(32'(display_val));
    press(1'b0, 1'b1, 16'd0);
    press(1'b0, 1'b1, 16'd0);
    expect_val("t6_in_b", 32'd1);       check(32'(state));
    press(1'b1, 1'b0, 16'h000F);
    press(1'b1, 1'b0, 16'd3);
    expect_val("t6_keep_a", alu_m(32'hF0, 32'hF, 2'd3)); check(32'(display_val));

    pulse_reset();

    // fill history past DEPTH, then pop back through it
    for (int k = 1; k <= 5; k++) begin
      press(1'b1, 1'b0, 16'(k));
      press(1'b1, 1'b0, 16'd0);
      press(1'b1, 1'b0, 16'd0);
      expect_val($sformatf("t4_res%0d", k), 32'(k)); check(32'(display_val));
      press(1'b1, 1'b0, 16'd0);
      exp_drop = 1'b0;
      if (model_hist.size() < DEPTH) begin
        model_hist.push_back(32'(k));
      end else begin
`ifdef HIST_OVERWRITE_EN
        void'(model_hist.pop_front());
        model_hist.push_back(32'(k));
`else
        exp_drop = 1'b1;
`endif
      end
      expect_val($sformatf("t4_cnt%0d", k), 32'(model_hist.size())); check(32'(hist_count));
      expect_val($sformatf("t4_drop%0d", k), 32'(exp_drop)); check(32'(drop));
      expect_val($sformatf("t4_full%0d", k), 32'(model_hist.size() == DEPTH)); check(32'(hist_full));
    end

    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 16'd0);
      if (model_hist.size() > 0) begin
        r = model_hist.pop_back();
        expect_val($sformatf("t4_pst%0d", i), 32'd3); check(32'(state));
        expect_val($sformatf("t4_pop%0d", i), r);     check(32'(display_val));
        expect_val($sformatf("t4_pcnt%0d", i), 32'(model_hist.size())); check(32'(hist_count));
        press(1'b0, 1'b1, 16'd0);
        press(1'b0, 1'b1, 16'd0);
        press(1'b0, 1'b1, 16'd0);
      end
      expect_val($sformatf("t4_back%0d", i), 32'd0); check(32'(state));
    end
    press(1'b0, 1'b1, 16'd0);
    expect_val("t4_last_state", 32'd0); check(32'(state));
    expect_val("t4_last_cnt", 32'(model_hist.size())); check(32'(hist_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
